// File: rtl/vram_px_writer.sv
// vram_px_writer: rectangle-fill engine for the 320x240 RGB888 pixel plane.
// Accepts one fill command at a time, optionally waits for the next
// frame-drawn rising edge, clips the rectangle to the visible area and then
// writes one pixel per arbiter grant in row-major order.
module vram_px_writer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              cmd_wait_frame,
  input  logic              frameDrawn,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we,
  input  logic              vram_grant,
  output logic              busy,
  output logic              done
);

  localparam logic [9:0]        H_RES_10 = 10'(H_RES);
  localparam logic [9:0]        V_RES_10 = 10'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CLIP  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [8:0]          w_q, w_d;
  logic [7:0]          h_q, h_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [9:0]          x_end_q, x_end_d;
  logic [9:0]          y_end_q, y_end_d;
  logic [9:0]          cur_x_q, cur_x_d;
  logic [9:0]          cur_y_q, cur_y_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0]   vram_d_q, vram_d_d;
  logic                vram_we_q, vram_we_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                frame_q;

  logic [9:0]          sum_x_s;
  logic [9:0]          sum_y_s;
  logic [9:0]          next_x_s;
  logic [ADDR_W-1:0]   row_y_s;
  logic                frame_rise_s;
  logic                row_last_s;
  logic                col_last_s;

  // Next-state and next-output computation for the fill sequencer.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    row_base_d  = row_base_q;
    vram_addr_d = vram_addr_q;
    vram_d_d    = vram_d_q;
    vram_we_d   = vram_we_q;

    // 10-bit sums cannot wrap: 511+511 and 255+255 both fit.
    sum_x_s      = {1'b0, x_q} + {1'b0, w_q};
    sum_y_s      = {2'b00, y_q} + {2'b00, h_q};
    next_x_s     = cur_x_q + 10'd1;
    row_y_s      = ADDR_W'(y_q) * H_RES_A;
    frame_rise_s = frameDrawn & ~frame_q;
    col_last_s   = (next_x_s == x_end_q);
    row_last_s   = ((cur_y_q + 10'd1) == y_end_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          if (cmd_wait_frame) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_CLIP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A level that was already high at acceptance never produces a rise.
        if (frame_rise_s) begin
          state_d = S_CLIP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CLIP: begin
        x_end_d = (sum_x_s > H_RES_10) ? H_RES_10 : sum_x_s;
        y_end_d = (sum_y_s > V_RES_10) ? V_RES_10 : sum_y_s;
        if ((w_q == 9'd0) || (h_q == 8'd0) ||
            ({1'b0, x_q} >= H_RES_10) || ({2'b00, y_q} >= V_RES_10)) begin
          state_d = S_DONE;
        end else begin
          cur_x_d     = {1'b0, x_q};
          cur_y_d     = {2'b00, y_q};
          row_base_d  = row_y_s;
          vram_addr_d = row_y_s + ADDR_W'(x_q);
          vram_d_d    = color_q;
          vram_we_d   = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address and data only move when the arbiter takes the current write.
        if (vram_grant) begin
          if (col_last_s && row_last_s) begin
            vram_we_d = 1'b0;
            state_d   = S_DONE;
          end else if (col_last_s) begin
            cur_x_d     = {1'b0, x_q};
            cur_y_d     = cur_y_q + 10'd1;
            row_base_d  = row_base_q + H_RES_A;
            vram_addr_d = row_base_q + H_RES_A + ADDR_W'(x_q);
            state_d     = S_WRITE;
          end else begin
            cur_x_d     = next_x_s;
            vram_addr_d = row_base_q + ADDR_W'(next_x_s);
            state_d     = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        vram_we_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the decoded next state.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= 9'd0;
      y_q         <= 8'd0;
      w_q         <= 9'd0;
      h_q         <= 8'd0;
      color_q     <= '0;
      x_end_q     <= 10'd0;
      y_end_q     <= 10'd0;
      cur_x_q     <= 10'd0;
      cur_y_q     <= 10'd0;
      row_base_q  <= '0;
      vram_addr_q <= '0;
      vram_d_q    <= '0;
      vram_we_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      row_base_q  <= row_base_d;
      vram_addr_q <= vram_addr_d;
      vram_d_q    <= vram_d_d;
      vram_we_q   <= vram_we_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Delayed copy of frameDrawn for edge detection, tracked in every state.
  always_ff @(posedge clk) begin
    frame_q <= frameDrawn;
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vram_we   = vram_we_q;
  assign vram_addr = vram_addr_q;
  assign vram_d    = vram_d_q;

endmodule
